// File: rtl/mem_access_pkg.sv
// mem_access_pkg: shared definitions for the MEM stage.
//   - MIPS opcode constants for the load/store subset handled here
//   - load-type encoding consumed by load_ext
//   - access size, FSM state encodings
//   - decoded-instruction and MEM/WB register structs, opcode decoder
package mem_access_pkg;

  localparam int NUM_LANES = 4;   // byte lanes per data word
  localparam int VEC_W     = 8;   // bits per lane

  localparam logic [5:0] OP_LB  = 6'h20;
  localparam logic [5:0] OP_LH  = 6'h21;
  localparam logic [5:0] OP_LW  = 6'h23;
  localparam logic [5:0] OP_LBU = 6'h24;
  localparam logic [5:0] OP_LHU = 6'h25;
  localparam logic [5:0] OP_SB  = 6'h28;
  localparam logic [5:0] OP_SH  = 6'h29;
  localparam logic [5:0] OP_SW  = 6'h2b;

  typedef enum logic [2:0] {LT_W, LT_H, LT_HU, LT_B, LT_BU} load_t;
  typedef enum logic [1:0] {SZ_B, SZ_H, SZ_W} size_t;
  typedef enum logic       {S_IDLE, S_WAIT} state_t;

  typedef struct packed {
    logic  ld;
    logic  st;
    size_t sz;
    load_t lt;
  } dec_t;

  typedef struct packed {
    logic        valid;
    logic [4:0]  ra3;
    logic [31:0] data;
    logic        bus_err;
    logic        align_err;
  } wb_t;

  function automatic dec_t decode(input logic [5:0] op);
    dec_t d;
    d.ld = 1'b0;
    d.st = 1'b0;
    d.sz = SZ_W;
    d.lt = LT_W;
    case (op)
      OP_LW:  begin d.ld = 1'b1; d.sz = SZ_W; d.lt = LT_W;  end
      OP_LH:  begin d.ld = 1'b1; d.sz = SZ_H; d.lt = LT_H;  end
      OP_LHU: begin d.ld = 1'b1; d.sz = SZ_H; d.lt = LT_HU; end
      OP_LB:  begin d.ld = 1'b1; d.sz = SZ_B; d.lt = LT_B;  end
      OP_LBU: begin d.ld = 1'b1; d.sz = SZ_B; d.lt = LT_BU; end
      OP_SW:  begin d.st = 1'b1; d.sz = SZ_W; end
      OP_SH:  begin d.st = 1'b1; d.sz = SZ_H; end
      OP_SB:  begin d.st = 1'b1; d.sz = SZ_B; end
      default: ;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/mem_access_load_ext.sv
// load_ext: combinational load lane select and sign/zero extension.
//   rdata  in  32  raw word from data memory
//   a      in  2   byte offset within the word
//   lt     in      load type (LT_W/LT_H/LT_HU/LT_B/LT_BU)
//   data   out 32  extended register write value
module load_ext
  import mem_access_pkg::*;
(
  input  logic [31:0] rdata,
  input  logic [1:0]  a,
  input  load_t       lt,
  output logic [31:0] data
);

  logic [NUM_LANES-1:0][VEC_W-1:0] lanes;
  logic [7:0]  b;
  logic [15:0] h;

  assign lanes = rdata;
  assign b     = lanes[a];
  assign h     = a[1] ? rdata[31:16] : rdata[15:0];

  always_comb begin
    data = rdata;
    case (lt)
      LT_H:    data = {{16{h[15]}}, h};
      LT_HU:   data = {16'h0, h};
      LT_B:    data = {{24{b[7]}}, b};
      LT_BU:   data = {24'h0, b};
      default: data = rdata;
    endcase
  end

endmodule

// File: rtl/mem_access.sv
// mem_access: MEM stage of the 5-stage MIPS pipeline.
// Issues req/ack data-memory accesses for lw/lh/lhu/lb/lbu/sw/sh/sb, builds
// byte enables and lane-replicated store data, extends load data, and
// registers the MEM/WB result. busy_MEM stalls upstream while an access waits.
// An access left unacknowledged for TIMEOUT_CYCLES cycles is aborted and
// retired with bus_err_WB.
// Optional feature macro: MEM_ALIGN_CHECK_EN -- misaligned lw/sw/lh/lhu/sh are
// not issued; they retire at once with align_err_WB=1 (extra output port).
// Ports:
//   clk, reset (async, active low)
//   valid_MEM, Instr_MEM, ALUout_MEM, WData_MEM, RegA3_MEM  : from EX
//   dm_req, dm_we, dm_addr, dm_be, dm_wdata / dm_rdata, dm_ack : memory bus
//   busy_MEM                                                 : stall upstream
//   valid_WB, RegA3_WB, WBData_WB, bus_err_WB [, align_err_WB] : MEM/WB regs
module mem_access
  import mem_access_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 16,
  parameter int TIMEOUT_W      = 5
)(
  input  logic        clk,
  input  logic        reset,
  input  logic        valid_MEM,
  input  logic [31:0] Instr_MEM,
  input  logic [31:0] ALUout_MEM,
  input  logic [31:0] WData_MEM,
  input  logic [4:0]  RegA3_MEM,
  output logic        dm_req,
  output logic        dm_we,
  output logic [31:0] dm_addr,
  output logic [3:0]  dm_be,
  output logic [31:0] dm_wdata,
  input  logic [31:0] dm_rdata,
  input  logic        dm_ack,
  output logic        busy_MEM,
  output logic        valid_WB,
  output logic [4:0]  RegA3_WB,
  output logic [31:0] WBData_WB,
`ifdef MEM_ALIGN_CHECK_EN
  output logic        align_err_WB,
`endif
  output logic        bus_err_WB
);

  state_t                 state, state_nxt;
  logic [TIMEOUT_W-1:0]   cnt, cnt_nxt;
  dec_t                   dec;
  logic [1:0]             a;
  logic                   mem_op, mis, go, abort;
  logic [31:0]            ld_data;
  wb_t                    wb_q, wb_d;
  logic [NUM_LANES-1:0][VEC_W-1:0] rt_l, wd_l;

  assign dec    = decode(Instr_MEM[31:26]);
  assign a      = ALUout_MEM[1:0];
  assign mem_op = valid_MEM & (dec.ld | dec.st);

`ifdef MEM_ALIGN_CHECK_EN
  assign mis = mem_op & (((dec.sz == SZ_W) & (a != 2'b00)) |
                         ((dec.sz == SZ_H) & a[0]));
  assign align_err_WB = wb_q.align_err;
`else
  assign mis = 1'b0;
`endif

  assign go    = mem_op & ~mis;
  assign abort = (state == S_WAIT) & ~dm_ack &
                 (cnt == TIMEOUT_W'(TIMEOUT_CYCLES - 1));

  // Gated by reset so a reset landing mid-access drops the bus immediately,
  // even while EX still presents the stalled memory instruction.
  assign dm_req   = reset & ((state == S_WAIT) | go);
  assign dm_we    = dm_req & dec.st;
  assign busy_MEM = reset & go & ~dm_ack & ~abort;
  assign dm_addr  = {ALUout_MEM[31:2], 2'b00};

  // Per-lane byte enable and store data steering.
  assign rt_l = WData_MEM;
  for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
    localparam logic [1:0] LN = 2'(i);
    assign dm_be[i] = (dec.sz == SZ_W) |
                      ((dec.sz == SZ_H) & (a[1] == LN[1])) |
                      ((dec.sz == SZ_B) & (a == LN));
    assign wd_l[i]  = (dec.sz == SZ_W) ? rt_l[i] :
                      (dec.sz == SZ_H) ? rt_l[i % 2] : rt_l[0];
  end
  assign dm_wdata = wd_l;

  load_ext u_load_ext (
    .rdata (dm_rdata),
    .a     (a),
    .lt    (dec.lt),
    .data  (ld_data)
  );

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    case (state)
      S_IDLE: if (go & ~dm_ack) begin
        state_nxt = S_WAIT;
        cnt_nxt   = TIMEOUT_W'(1);
      end
      S_WAIT: if (dm_ack | abort) begin
        state_nxt = S_IDLE;
        cnt_nxt   = '0;
      end else begin
        cnt_nxt = cnt + TIMEOUT_W'(1);
      end
      default: begin
        state_nxt = S_IDLE;
        cnt_nxt   = '0;
      end
    endcase
  end

  // MEM/WB next value: bubble while stalled, error retire on abort or
  // misalignment, otherwise the normal retire.
  always_comb begin
    wb_d = '0;
    if (busy_MEM) begin
      wb_d = '0;
    end else if (abort) begin
      wb_d.valid   = 1'b1;
      wb_d.bus_err = 1'b1;
    end else if (mis) begin
      wb_d.valid     = 1'b1;
      wb_d.align_err = 1'b1;
      wb_d.data      = ALUout_MEM;
    end else begin
      wb_d.valid = valid_MEM;
      wb_d.ra3   = dec.st ? 5'd0 : RegA3_MEM;
      wb_d.data  = (mem_op & dec.ld) ? ld_data : ALUout_MEM;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= S_IDLE;
      cnt   <= '0;
      wb_q  <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      wb_q  <= wb_d;
    end
  end

  assign valid_WB   = wb_q.valid;
  assign RegA3_WB   = wb_q.ra3;
  assign WBData_WB  = wb_q.data;
  assign bus_err_WB = wb_q.bus_err;

  // Only the opcode field is decoded here.
  logic unused_bits;
`ifdef MEM_ALIGN_CHECK_EN
  assign unused_bits = ^Instr_MEM[25:0];
`else
  assign unused_bits = ^{Instr_MEM[25:0], wb_q.align_err};
`endif

endmodule
